// File: rtl/align_buffer.sv
// align_buffer
// ------------
// Collects aligned symbol pairs emitted by a traceback stage (end-to-start
// order), then replays them to a consumer in forward (start-to-end) order.
// Pairs are pushed onto a stack while traceback runs and popped once it ends.
//
// Optional feature: define ALIGN_STATS_EN to add the match_cnt / gap_cnt
// statistics outputs. Without it those ports and their logic are absent.
//
// Ports
//   clk, rst       clock; synchronous active-high reset
//   en_traceB      traceback-active strobe (delayed one cycle internally so it
//                  lines up with the registered datoA/datoB)
//   datoA, datoB   aligned symbols; {datoA,datoB} == 0 marks "no pair"
//   tb_done        one-cycle pulse: traceback reached cell (0,0)
//   final_score    alignment score, latched into score_out on tb_done
//   out_valid      outA/outB/out_last hold a pair
//   out_ready      consumer accepts the presented pair
//   outA, outB     replayed pair (zero while out_valid is low)
//   out_last       presented pair is the final one
//   score_out      latched final score
//   busy           collecting or draining
//   overflow       sticky: a push was dropped because the stack was full
//   match_cnt      (ALIGN_STATS_EN) pushes with datoA == datoB, neither a gap
//   gap_cnt        (ALIGN_STATS_EN) pushes with datoA or datoB a gap
//   state_dbg      current FSM state (IDLE=0, COLLECT=1, DRAIN=2)
//
// Output handshake: a pair transfers on every rising edge where out_valid and
// out_ready are both high. While out_valid is high and out_ready is low the
// presented pair and out_last hold stable; out_valid never drops without a
// transfer (except on reset).

module align_buffer #(
  parameter int         N     = 128,
  parameter int         DEPTH = 2*N,
  parameter logic [2:0] dash  = 3'b111
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en_traceB,
  input  logic [2:0]        datoA,
  input  logic [2:0]        datoB,
  input  logic              tb_done,
  input  logic signed [8:0] final_score,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2:0]        outA,
  output logic [2:0]        outB,
  output logic              out_last,
  output logic signed [8:0] score_out,
  output logic              busy,
  output logic              overflow,
`ifdef ALIGN_STATS_EN
  output logic [8:0]        match_cnt,
  output logic [8:0]        gap_cnt,
`endif
  output logic [1:0]        state_dbg
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DRAIN   = 2'd2
  } state_t;

  state_t            state_q, state_n;
  logic              en_d;
  logic [CW-1:0]     count_q, count_n;
  logic [5:0]        mem [DEPTH];

  logic [5:0]        pair;
  logic              push;
  logic              full;
  logic              stored;
  logic              wr_en;
  logic [AW-1:0]     wr_addr;
  logic [AW-1:0]     rd_addr;
  logic [5:0]        rd_pair;

  logic              ov_n, last_n, ovf_n;
  logic [2:0]        a_n, b_n;
  logic signed [8:0] score_n;

  // N only sets DEPTH's default and dash only feeds the optional statistics;
  // this sink keeps both referenced in every build.
  logic unused_params;
  assign unused_params = ^{N[0], dash};

  assign pair      = {datoA, datoB};
  assign push      = en_d && (pair != 6'b0);
  assign full      = (count_q == CW'(DEPTH));
  assign rd_pair   = mem[rd_addr];
  assign busy      = (state_q != IDLE);
  assign state_dbg = state_q;

  always_comb begin
    state_n = state_q;
    count_n = count_q;
    ov_n    = out_valid;
    a_n     = outA;
    b_n     = outB;
    last_n  = out_last;
    ovf_n   = overflow;
    score_n = score_out;
    stored  = 1'b0;
    wr_en   = 1'b0;
    wr_addr = AW'(count_q);
    // Default read is the current top of stack.
    rd_addr = AW'(count_q - CW'(1));

    case (state_q)
      IDLE: begin
        if (push) begin
          wr_en   = 1'b1;
          wr_addr = '0;
          stored  = 1'b1;
          count_n = CW'(1);
          ovf_n   = 1'b0;
          state_n = COLLECT;
        end
      end
      COLLECT: begin
        if (push) begin
          if (full) begin
            ovf_n = 1'b1;
          end else begin
            wr_en   = 1'b1;
            stored  = 1'b1;
            count_n = count_q + CW'(1);
          end
        end
      end
      DRAIN: begin
        if (out_valid && out_ready) begin
          if (count_q == CW'(1)) begin
            state_n = IDLE;
            count_n = '0;
            ov_n    = 1'b0;
            a_n     = 3'd0;
            b_n     = 3'd0;
            last_n  = 1'b0;
          end else begin
            // Next pair is already in memory: present it without a bubble.
            count_n    = count_q - CW'(1);
            rd_addr    = AW'(count_q - CW'(2));
            {a_n, b_n} = rd_pair;
            last_n     = (count_q == CW'(2));
          end
        end
      end
      default: state_n = IDLE;
    endcase

    // End of traceback outside DRAIN. A push in the same cycle has already
    // been folded into count_n, and the pushed pair is the new top, so it is
    // forwarded directly instead of read back from memory.
    if (tb_done && (state_q != DRAIN)) begin
      score_n = final_score;
      if (state_n == COLLECT) begin
        if (count_n == '0) begin
          state_n = IDLE;
        end else begin
          state_n    = DRAIN;
          ov_n       = 1'b1;
          last_n     = (count_n == CW'(1));
          {a_n, b_n} = stored ? pair : rd_pair;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      count_q   <= '0;
      en_d      <= 1'b0;
      out_valid <= 1'b0;
      outA      <= 3'd0;
      outB      <= 3'd0;
      out_last  <= 1'b0;
      overflow  <= 1'b0;
      score_out <= '0;
    end else begin
      state_q   <= state_n;
      count_q   <= count_n;
      en_d      <= en_traceB;
      out_valid <= ov_n;
      outA      <= a_n;
      outB      <= b_n;
      out_last  <= last_n;
      overflow  <= ovf_n;
      score_out <= score_n;
    end
  end

  // Stack storage has no reset; contents are only read below count.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= pair;
    end
  end

`ifdef ALIGN_STATS_EN
  logic is_match, is_gap;
  assign is_match = (datoA == datoB) && (datoA != dash);
  assign is_gap   = (datoA == dash) || (datoB == dash);

  // Every push seen while collecting is counted, including ones dropped on a
  // full stack; the first push of a traceback restarts both counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      match_cnt <= '0;
      gap_cnt   <= '0;
    end else if (push && (state_q == IDLE)) begin
      match_cnt <= {8'd0, is_match};
      gap_cnt   <= {8'd0, is_gap};
    end else if (push && (state_q == COLLECT)) begin
      match_cnt <= match_cnt + {8'd0, is_match};
      gap_cnt   <= gap_cnt + {8'd0, is_gap};
    end
  end
`endif

endmodule

// File: doc/align_buffer.md
ALIGN_BUFFER -- requirements
Module: align_buffer

Interface
REQ-001 Parameter N, default 128: maximum sequence length.
REQ-002 Parameter DEPTH, default 2*N: stack capacity in aligned pairs.
REQ-003 Parameter dash, default 3'b111: gap symbol code.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 en_traceB  input  1  traceback-active strobe, same signal that drives the scoring stage.
REQ-007 datoA  input  3  aligned symbol, sequence A, registered by scoring stage.
REQ-008 datoB  input  3  aligned symbol, sequence B, registered by scoring stage.
REQ-009 tb_done  input  1  single-cycle pulse: traceback reached cell (0,0).
REQ-010 final_score  input  signed 9  alignment score from scoring stage.
REQ-011 out_valid  output  1  outA/outB/out_last hold a valid pair.
REQ-012 out_ready  input  1  consumer accepts the pair when out_valid is high.
REQ-013 outA, outB  output  3 each  aligned pair, forward (start-to-end) order.
REQ-014 out_last  output  1  current pair is the final one.
REQ-015 score_out  output  signed 9  latched final score.
REQ-016 busy  output  1  high in COLLECT or DRAIN.
REQ-017 overflow  output  1  sticky: a push was dropped because the stack was full.

Function
REQ-018 The block SHALL keep en_d, en_traceB delayed one clk. A push occurs when en_d=1 and {datoA,datoB} != 6'b0.
REQ-019 The stack SHALL store DEPTH 6-bit entries, with count 0..DEPTH of width $clog2(DEPTH+1).
REQ-020 FSM states: IDLE, COLLECT, DRAIN.
REQ-021 IDLE->COLLECT on the first push: that pair is stored, count=1, overflow cleared in the same cycle.
REQ-022 In COLLECT, each push SHALL write mem[count] and increment count.
REQ-023 A push at count==DEPTH SHALL be dropped, set overflow, and leave count unchanged.
REQ-024 COLLECT->DRAIN on tb_done. score_out latches final_score in that cycle.
REQ-025 If tb_done and a push coincide, the push SHALL be stored before the transition.
REQ-026 If tb_done occurs in COLLECT with count==0, the block SHALL return to IDLE with score_out latched and out_valid never asserted.
REQ-027 tb_done in IDLE SHALL only latch score_out and leave the state unchanged.
REQ-028 Entering DRAIN SHALL load output registers from mem[count-1]. out_valid SHALL be 1 in the next cycle, which is one cycle of latency after tb_done.
REQ-029 On out_valid&&out_ready, the block SHALL decrement count and load mem[count-2] the next cycle with no bubble. out_last=1 when the presented pair is the final one (count==1).
REQ-030 Handshake on the final pair SHALL drop out_valid the next cycle and return the FSM to IDLE.
REQ-031 While out_valid=1 and out_ready=0, outA/outB/out_last SHALL hold stable.
REQ-032 Pushes arriving in DRAIN SHALL be ignored and SHALL NOT set overflow.
REQ-033 When out_valid=0, outA, outB and out_last SHALL be 0.

Reset
REQ-034 When rst=1 at a clk edge, the block SHALL set state=IDLE, count=0, en_d=0, out_valid=0, outA=outB=0, out_last=0, busy=0, overflow=0 and score_out=0. Memory contents are don't-care.
REQ-035 rst mid-COLLECT or mid-DRAIN SHALL discard all stored pairs and apply the values of REQ-034 on the next edge.

Configuration
REQ-036 Macro ALIGN_STATS_EN, when defined, SHALL add two 9-bit outputs: match_cnt (pushes with datoA==datoB and neither equal to dash) and gap_cnt (pushes with datoA==dash or datoB==dash).
REQ-037 Both counters SHALL be cleared on rst and on IDLE->COLLECT (the first push then counts), and SHALL hold their values through DRAIN and IDLE.
REQ-038 Without ALIGN_STATS_EN, these ports and their logic SHALL be absent and all other behaviour is identical.

Verification
REQ-039 The bench SHALL cover each of the following directed scenarios:
- Push (1,1),(2,dash),(3,4), then tb_done with final_score=-2, out_ready=1 -> outputs (3,4),(2,dash),(1,1) on consecutive cycles; out_last only on (1,1); score_out=-2.
- Same stimulus with out_ready held 0 for 5 cycles -> the first pair is held stable with out_valid=1 and no pop occurs.
- DEPTH+3 pushes, then tb_done -> overflow=1, exactly DEPTH pairs drained, the first drained pair is the DEPTH-th pushed.
- rst asserted after the second pop of a 4-pair drain -> next cycle out_valid=0, busy=0, count=0; a new traceback drains correctly.
- tb_done coinciding with the 3rd push -> 3 pairs drained; tb_done with no prior push -> out_valid stays 0, state IDLE.
- With ALIGN_STATS_EN and pushes (1,1),(1,2),(dash,3),(4,dash) -> match_cnt=1, gap_cnt=2.
